fir_serial_mac: RTL and testbench
=================================

# fir_serial_mac

Parametrised, time-multiplexed low-pass FIR filter for the ECG noise-reduction datapath. It is the successor to the fully parallel 101-tap filter. One shared multiply-accumulate unit runs over a circular sample buffer. Coefficients are loadable at run time instead of fixed at elaboration, samples enter and leave through a valid/ready handshake, and the output is rounded and saturated to a configurable width. It sits between the ECG sample source (16-bit samples, pre-scaled by 10000) and the downstream logger/display stage.

## Interface
- DATA_W, 16: sample width, signed.
- COEF_W, 16: coefficient width, signed.
- TAPS, 101: number of taps; must be at least 2.
- ACC_W, 40: accumulator width; must be at least DATA_W+COEF_W+clog2(TAPS).
- OUT_W, 32: output width, signed; must be at most ACC_W.
- SHIFT, 0: right shift applied to the accumulator before saturation; range 0 to ACC_W-OUT_W.
- Clk  in  1  single clock; all logic uses the rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Coef_we  in  1  coefficient write strobe.
- Coef_addr  in  clog2(TAPS)  tap index k; values of TAPS or above are ignored.
- Coef_din  in  COEF_W  coefficient H[k].
- In_valid  in  1  Xin is valid.
- In_ready  out  1  block can accept a sample.
- Xin  in  DATA_W  input sample x[n].
- Out_valid  out  1  one-cycle pulse; Yout is valid.
- Yout  out  OUT_W  filtered sample y[n].
- Sat_flag  out  1  Yout was clipped; qualified by Out_valid.

## Operation
- Reset (asynchronous):
  - State goes to IDLE.
  - All H[k], all sample-buffer entries, the write pointer and the accumulator are cleared to 0.
  - Output values during reset: In_ready=0, Out_valid=0, Yout=0, Sat_flag=0.
  - In_ready rises on the first clock edge after Rst_n deasserts.
- IDLE:
  - In_ready=1.
  - A write (Coef_we=1 with Coef_addr < TAPS) stores Coef_din into H[Coef_addr].
  - An accept (In_valid && In_ready) does three things on that edge: advances the write pointer mod TAPS, stores Xin at the new pointer, and clears the accumulator. State goes to MAC, with tap counter k=0.
  - If a write and an accept happen on the same edge, both take effect. The new coefficient is used for the sample just accepted.
- MAC:
  - Lasts exactly TAPS cycles, with In_ready=0.
  - Each cycle: acc += H[k] * buf[(wptr - k) mod TAPS], then k increments. The index wraps below 0 back to TAPS-1.
  - Products are full-precision signed (DATA_W+COEF_W bits), sign-extended to ACC_W. No truncation occurs inside the accumulator.
  - Coef_we is ignored in MAC and in OUT.
  - After k = TAPS-1 completes, state goes to OUT.
- OUT (one cycle):
  - If SHIFT>0, round half up: r = (acc + 2^(SHIFT-1)) >>> SHIFT. If SHIFT=0, r = acc.
  - If r fits in OUT_W signed: Yout=r, Sat_flag=0.
  - Otherwise Yout = +2^(OUT_W-1)-1 or -2^(OUT_W-1) according to the sign of r, and Sat_flag=1.
  - Out_valid=1 for exactly this one cycle. State returns to IDLE.
  - There is no output backpressure. Downstream must take the sample during the Out_valid cycle.
- Yout and Sat_flag hold their last values until the next OUT.
- Reset asserted in any state aborts the in-flight computation. No Out_valid is produced for it.

## Timing
- Accept edge E. MAC updates happen on edges E+1 through E+TAPS.
- Yout, Sat_flag and Out_valid are registered on edge E+TAPS+1 and stay high for one cycle.
- In_ready is 0 from edge E until edge E+TAPS+1. It is 1 again in the same cycle as Out_valid.
- Earliest next accept is edge E+TAPS+2. Throughput is one sample per TAPS+2 cycles: 103 cycles at the default TAPS=101.
- With In_valid held high continuously, samples are accepted exactly every TAPS+2 cycles. No sample is duplicated or dropped relative to the accept edges.

## Test plan
- Reset: hold Rst_n=0 with random inputs, then release.
  - During reset: In_ready=0, Out_valid=0, Yout=0, Sat_flag=0.
  - In_ready=1 one edge after release.
- Impulse (TAPS=8, SHIFT=0): load H[k]=k+1, then feed 1,0,0,... through 10 samples.
  - Yout = 1,2,3,4,5,6,7,8,0,0.
  - Each Out_valid comes 9 cycles after its accept.
- DC with buffer wrap (TAPS=8): all H=100; feed Xin=100 for 12 samples.
  - Yout = 10000, 20000, …, 80000, then 80000 for every remaining sample.
- Rounding (SHIFT=4):
  - Accumulator 24 → Yout=2.
  - Accumulator -24 → Yout=-1.
  - Accumulator 7 → Yout=0.
- Saturation (OUT_W=16, TAPS=8): all H=32767.
  - Xin=32767 → Yout=32767, Sat_flag=1.
  - Xin=-32768 → Yout=-32768, Sat_flag=1.
  - Xin=0 → Sat_flag=0.
- Handshake and abort:
  - Coef_we pulsed during MAC → H is unchanged and the output matches the old coefficients.
  - Rst_n pulsed low mid-MAC → no Out_valid for that sample, and the next impulse response starts from an all-zero buffer with all-zero coefficients.

Source files
------------

// File: rtl/fir_serial_mac.sv
// fir_serial_mac: time-multiplexed FIR filter, one shared MAC over a circular sample buffer,
// run-time loadable coefficients, valid/ready input and rounded/saturated output.
module fir_serial_mac #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int TAPS   = 101,
   parameter int ACC_W  = 40,
   parameter int OUT_W  = 32,
   parameter int SHIFT  = 0,
   localparam int AW    = $clog2(TAPS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              coef_we_i,
   input  logic [AW-1:0]     coef_addr_i,
   input  logic [COEF_W-1:0] coef_din_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] xin_i,
   output logic              out_valid_o,
   output logic [OUT_W-1:0]  yout_o,
   output logic              sat_flag_o
);
   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
   localparam logic [AW:0] TP = (AW+1)'(TAPS);
   localparam logic signed [ACC_W:0] HALF = ((ACC_W+1)'(1) << SHIFT) >> 1;
   state_t state_q;
   logic signed [COEF_W-1:0] h_q [TAPS];
   logic signed [DATA_W-1:0] sbuf_q [TAPS];
   logic [AW-1:0] wptr_q, wptr_d, k_q, idx;
   logic [AW:0] dif;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [DATA_W+COEF_W-1:0] prod;
   logic signed [ACC_W:0] rnd;
   logic [ACC_W-OUT_W:0] top;
   logic [OUT_W-1:0] yout_q, yout_d;
   logic in_ready_q, out_valid_q, sat_q, sat_d, accept, coef_ok;
   assign accept  = in_valid_i && in_ready_q;
   assign coef_ok = coef_we_i && state_q == IDLE && {1'b0, coef_addr_i} < TP;
   assign wptr_d  = wptr_q == AW'(TAPS-1) ? '0 : wptr_q + AW'(1);
   // (wptr - k) mod TAPS, computed without going negative
   assign dif     = {1'b0, wptr_q} + TP - {1'b0, k_q};
   assign idx     = AW'(dif >= TP ? dif - TP : dif);
   assign prod    = h_q[k_q] * sbuf_q[idx];
   assign acc_d   = acc_q + ACC_W'(prod);
   assign rnd     = ((ACC_W+1)'(acc_q) + HALF) >>> SHIFT;
   assign top     = rnd[ACC_W:OUT_W-1];
   assign sat_d   = !(&top || ~|top);
   assign yout_d  = sat_d ? {rnd[ACC_W], {(OUT_W-1){~rnd[ACC_W]}}} : rnd[OUT_W-1:0];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wptr_q      <= '0;
         k_q         <= '0;
         acc_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         yout_q      <= '0;
         sat_q       <= 1'b0;
         for (int i = 0; i < TAPS; i++) begin
            h_q[i]    <= '0;
            sbuf_q[i] <= '0;
         end
      end else begin
         out_valid_q <= 1'b0;
         if (coef_ok) h_q[coef_addr_i] <= coef_din_i;
         case (state_q)
            IDLE: begin
               in_ready_q <= !accept;
               if (accept) begin
                  wptr_q         <= wptr_d;
                  sbuf_q[wptr_d] <= xin_i;
                  acc_q          <= '0;
                  k_q            <= '0;
                  state_q        <= MAC;
               end
            end
            MAC: begin
               acc_q <= acc_d;
               k_q   <= k_q + AW'(1);
               if (k_q == AW'(TAPS-1)) state_q <= OUT;
            end
            default: begin
               yout_q      <= yout_d;
               sat_q       <= sat_d;
               out_valid_q <= 1'b1;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end
   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign yout_o      = yout_q;
   assign sat_flag_o  = sat_q;
endmodule

// File: tb/tb_fir_serial_mac.sv
// tb_fir_serial_mac: two filter instances (full-width/no shift and 16-bit/shift 4) driven in lockstep
// and compared against a sample-history reference model.
module tb_fir_serial_mac;
   localparam int T = 8;
   logic clk = 1'b0, rst_n = 1'b0, coef_we = 1'b0, in_valid = 1'b0;
   logic [2:0] coef_addr = '0;
   logic signed [15:0] coef_din = '0, xin = '0;
   logic rdy0, rdy1, ov0, ov1, s0, s1;
   logic signed [31:0] y0;
   logic signed [15:0] y1;
   int checks = 0, errors = 0;
   int h[T];
   int hist[$];
   longint obs_y0, obs_y1;
   bit obs_s1;
   always #5 clk = ~clk;
   fir_serial_mac #(.TAPS(T)) u0 (
      .clk(clk), .rst_n(rst_n), .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_din_i(coef_din),
      .in_valid_i(in_valid), .in_ready_o(rdy0), .xin_i(xin), .out_valid_o(ov0), .yout_o(y0), .sat_flag_o(s0));
   fir_serial_mac #(.TAPS(T), .OUT_W(16), .SHIFT(4)) u1 (
      .clk(clk), .rst_n(rst_n), .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_din_i(coef_din),
      .in_valid_i(in_valid), .in_ready_o(rdy1), .xin_i(xin), .out_valid_o(ov1), .yout_o(y1), .sat_flag_o(s1));
   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   function automatic longint ref_acc();
      longint a = 0;
      for (int k = 0; k < T; k++) if (k < hist.size()) a += longint'(h[k]) * longint'(hist[k]);
      return a;
   endfunction
   function automatic longint scale(input longint a, input int sh, input int ow, output bit sat);
      longint r, mx;
      r = sh > 0 ? (a + (longint'(1) << (sh - 1))) >>> sh : a;
      mx = (longint'(1) << (ow - 1)) - 1;
      sat = r > mx || r < -mx - 1;
      return r > mx ? mx : (r < -mx - 1 ? -mx - 1 : r);
   endfunction
   task automatic clear_model();
      foreach (h[k]) h[k] = 0;
      hist.delete();
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (4) begin
         coef_we = 1'($urandom);
         in_valid = 1'($urandom);
         coef_addr = 3'($urandom);
         coef_din = 16'($urandom);
         xin = 16'($urandom);
         @(negedge clk);
      end
      chk("rst_ready", {rdy0, rdy1}, 0);
      chk("rst_out_valid", {ov0, ov1}, 0);
      chk("rst_yout0", y0, 0);
      chk("rst_yout1", y1, 0);
      chk("rst_sat", {s0, s1}, 0);
      coef_we = 1'b0;
      in_valid = 1'b0;
      rst_n = 1'b1;
      clear_model();
      @(negedge clk);
      chk("release_ready", {rdy0, rdy1}, 3);
   endtask
   task automatic wcoef(input int k, input int v);
      coef_we = 1'b1;
      coef_addr = 3'(k);
      coef_din = 16'(v);
      @(negedge clk);
      coef_we = 1'b0;
      h[k] = v;
   endtask
   task automatic loadall(input int base, input int step);
      for (int k = 0; k < T; k++) wcoef(k, base + step * k);
   endtask
   // mode 0: plain sample; 1: coefficient write on the accept edge; 2: coefficient write during MAC
   task automatic send(input int x, input int mode, input int wa, input int wv);
      int j;
      bit es0, es1;
      longint e0, e1;
      j = 0;
      while (!(rdy0 && rdy1) && j < 200) begin
         @(negedge clk);
         j++;
      end
      chk("ready_wait", rdy0 && rdy1, 1);
      in_valid = 1'b1;
      xin = 16'(x);
      if (mode == 1) begin
         coef_we = 1'b1;
         coef_addr = 3'(wa);
         coef_din = 16'(wv);
         h[wa] = wv;
      end
      @(posedge clk);
      hist.push_front(x);
      if (hist.size() > T) void'(hist.pop_back());
      e0 = scale(ref_acc(), 0, 32, es0);
      e1 = scale(ref_acc(), 4, 16, es1);
      @(negedge clk);
      in_valid = 1'b0;
      coef_we = 1'b0;
      chk("busy", {rdy0, rdy1, ov0, ov1}, 0);
      j = 0;
      if (mode == 2) begin
         coef_we = 1'b1;
         coef_addr = 3'(wa);
         coef_din = 16'(wv);
         @(negedge clk);
         coef_we = 1'b0;
         j = 1;
      end
      while (!ov0 && j < 40) begin
         @(negedge clk);
         j++;
      end
      chk("out_latency", j, T + 1);
      chk("out_valid1", ov1, 1);
      chk("ready_with_out", {rdy0, rdy1}, 3);
      chk("yout0", y0, e0);
      chk("sat0", s0, es0);
      chk("yout1", y1, e1);
      chk("sat1", s1, es1);
      obs_y0 = y0;
      obs_y1 = y1;
      obs_s1 = s1;
   endtask
   task automatic abort();
      bit seen;
      seen = 1'b0;
      in_valid = 1'b1;
      xin = 16'sd5;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_mac", {rdy0, rdy1, ov0, ov1}, 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      clear_model();
      repeat (2 * T) begin
         @(negedge clk);
         seen |= ov0 | ov1;
      end
      chk("abort_no_out", seen, 0);
   endtask
   initial begin
      do_reset();
      loadall(1, 1);
      for (int i = 0; i < 10; i++) begin
         send(i == 0 ? 1 : 0, 0, 0, 0);
         chk("impulse", obs_y0, i < 8 ? i + 1 : 0);
      end
      do_reset();
      loadall(100, 0);
      for (int i = 0; i < 12; i++) begin
         send(100, 0, 0, 0);
         chk("dc", obs_y0, (i < 8 ? i + 1 : 8) * 10000);
      end
      do_reset();
      wcoef(0, 24);
      send(1, 0, 0, 0);
      chk("round_p24", obs_y1, 2);
      send(-1, 0, 0, 0);
      chk("round_m24", obs_y1, -1);
      wcoef(0, 7);
      send(1, 0, 0, 0);
      chk("round_7", obs_y1, 0);
      do_reset();
      loadall(32767, 0);
      send(32767, 0, 0, 0);
      chk("sat_pos_y", obs_y1, 32767);
      chk("sat_pos_f", obs_s1, 1);
      do_reset();
      loadall(32767, 0);
      send(-32768, 0, 0, 0);
      chk("sat_neg_y", obs_y1, -32768);
      chk("sat_neg_f", obs_s1, 1);
      for (int i = 0; i < T; i++) send(0, 0, 0, 0);
      chk("sat_zero_f", obs_s1, 0);
      do_reset();
      loadall(1, 1);
      send(3, 2, 0, 1000);
      chk("we_in_mac", obs_y0, 3);
      send(2, 0, 0, 0);
      chk("we_in_mac_kept", obs_y0, 8);
      send(1, 1, 0, 50);
      chk("we_with_accept", obs_y0, 63);
      abort();
      send(1, 0, 0, 0);
      chk("post_abort_zero_h", obs_y0, 0);
      loadall(1, 1);
      send(0, 0, 0, 0);
      chk("post_abort_clean_buf", obs_y0, 2);
      do_reset();
      for (int k = 0; k < T; k++) wcoef(k, int'($urandom_range(65535)) - 32768);
      for (int i = 0; i < 16; i++)
         send(int'($urandom_range(65535)) - 32768, int'($urandom_range(2)),
              int'($urandom_range(T - 1)), int'($urandom_range(65535)) - 32768);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
